// File: rtl/spi_ram_master.sv
// SPI master for the on-chip SPI RAM slave: frames {cmd, payload} on MOSI
// under SS_n and, for read-data commands, captures the 8-bit reply from MISO.
module spi_ram_master #(
  parameter int RD_LATENCY = 3,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE, SEL, SHIFT, HOLD, WAIT_RD, READ, STOP
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [9:0] frame;
  logic [7:0] cap;
  logic       is_rd;
  logic       cap_en;
  logic       next_last;

  assign is_rd = (frame[9:8] == 2'b11);

  // MISO is sampled on the edge that leaves WAIT_RD and on every READ edge
  // except the one that moves to STOP: eight samples, MSB first.
  assign cap_en = ((state == WAIT_RD) && (cnt == LAT_LAST)) ||
                  ((state == READ) && (cnt != 4'd7));

  // High when the coming cycle is the final STOP cycle of the transaction.
  assign next_last = (((state == HOLD) || ((state == READ) && (cnt == 4'd7))) &&
                      (GAP_LAST == 4'd0)) ||
                     ((state == STOP) && (cnt != GAP_LAST) &&
                      ((cnt + 4'd1) == GAP_LAST));

  always_ff @(posedge clk) begin
    if ((state == IDLE) && start)
      frame <= {cmd, (cmd == 2'b11) ? 8'h00 : wr_data};
    if (cap_en)
      cap <= {cap[6:0], MISO};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done     <= next_last;
      rd_valid <= next_last && is_rd;
      if (next_last && is_rd)
        rd_data <= cap;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SEL;
            busy  <= 1'b1;
            SS_n  <= 1'b0;
            MOSI  <= 1'b0;
          end
        end
        SEL: begin
          state <= SHIFT;
          cnt   <= 4'd9;
          MOSI  <= frame[9];
        end
        SHIFT: begin
          if (cnt == 4'd0) begin
            MOSI  <= 1'b0;
            state <= is_rd ? WAIT_RD : HOLD;
          end else begin
            cnt  <= cnt - 4'd1;
            MOSI <= frame[cnt - 4'd1];
          end
        end
        HOLD: begin
          state <= STOP;
          cnt   <= 4'd0;
          SS_n  <= 1'b1;
        end
        WAIT_RD: begin
          if (cnt == LAT_LAST) begin
            state <= READ;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        READ: begin
          if (cnt == 4'd7) begin
            state <= STOP;
            cnt   <= 4'd0;
            SS_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        STOP: begin
          MOSI <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
